// File: rtl/pe_hist_mac.sv
// -----------------------------------------------------------------------------
// pe_hist_mac
// Log-domain bit-sparsity processing element, parametrised in lane count and
// bin/accumulator widths. Each lane adds its A/B exponents and XORs the signs.
// Masked lanes are dropped. The remaining terms build a signed per-exponent
// histogram that accumulates across the beats of a frame. When the last beat
// has been folded in, a Horner walk from the top bin down reduces the
// histogram to sum(bin[k] * 2^k).
//
// Pipeline: S1 lane register -> per-bin delta register -> histogram bins.
//           Result latency is last-accept edge + 2 + NBINS.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   IN_VALID/IN_READY   input beat handshake; IN_LAST closes the frame
//   A_EXPS, B_EXPS      packed exponents, lane i = [i*EXP_W +: EXP_W]
//   A_SIGNS, B_SIGNS    per-lane signs, 1 = negative
//   LANE_MASK           1 = lane carries a nonzero term
//   OUT_VALID/OUT_READY result handshake
//   OUT_RESULT          signed frame result (ACC_W bits)
//   OUT_OVF             sticky saturation flag for the frame
//
// Build option: define PE_HIST_SAT_EN for saturating bins/accumulator with
// OUT_OVF reporting. Without it, bins and accumulator wrap and OUT_OVF stays 0.
// -----------------------------------------------------------------------------
module pe_hist_mac #(
  parameter int LANES = 16,
  parameter int EXP_W = 3,
  parameter int CNT_W = 8,
  parameter int ACC_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic                   IN_LAST,
  input  logic [LANES*EXP_W-1:0] A_EXPS,
  input  logic [LANES-1:0]       A_SIGNS,
  input  logic [LANES*EXP_W-1:0] B_EXPS,
  input  logic [LANES-1:0]       B_SIGNS,
  input  logic [LANES-1:0]       LANE_MASK,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [ACC_W-1:0]       OUT_RESULT,
  output logic                   OUT_OVF
);

  localparam int SUM_W = EXP_W + 1;
  localparam int NBINS = (1 << SUM_W) - 1;
  // Per-bin delta range is +/-LANES, plus a sign bit.
  localparam int DW    = $clog2(LANES + 1) + 1;

  localparam logic [SUM_W-1:0]     K_LAST = SUM_W'(NBINS - 1);
  localparam logic signed [DW-1:0] D_ONE  = {{(DW-1){1'b0}}, 1'b1};

`ifdef PE_HIST_SAT_EN
  localparam int SW  = ((CNT_W > DW) ? CNT_W : DW) + 1;
  localparam int AW2 = ACC_W + 2;
  localparam logic signed [SW-1:0]  BIN_MAX = {{(SW-CNT_W+1){1'b0}}, {(CNT_W-1){1'b1}}};
  localparam logic signed [SW-1:0]  BIN_MIN = -BIN_MAX;
  localparam logic signed [AW2-1:0] ACC_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [AW2-1:0] ACC_MIN = -ACC_MAX;
`endif

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_REDUCE = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  // Bin update: bin + delta, clamped symmetrically or wrapped.
  function automatic logic signed [CNT_W-1:0] bin_add(
    input  logic signed [CNT_W-1:0] bin,
    input  logic signed [DW-1:0]    delta,
    output logic                    sat
  );
`ifdef PE_HIST_SAT_EN
    logic signed [SW-1:0] s;
    s = SW'(bin) + SW'(delta);
    if (s > BIN_MAX) begin
      sat     = 1'b1;
      bin_add = BIN_MAX[CNT_W-1:0];
    end else if (s < BIN_MIN) begin
      sat     = 1'b1;
      bin_add = BIN_MIN[CNT_W-1:0];
    end else begin
      sat     = 1'b0;
      bin_add = s[CNT_W-1:0];
    end
`else
    sat     = 1'b0;
    bin_add = bin + CNT_W'(delta);
`endif
  endfunction

  // One Horner step: 2*acc + bin, clamped symmetrically or wrapped.
  function automatic logic signed [ACC_W-1:0] acc_step(
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [CNT_W-1:0] bin,
    output logic                    sat
  );
`ifdef PE_HIST_SAT_EN
    logic signed [AW2-1:0] s;
    s = (AW2'(acc) <<< 1) + AW2'(bin);
    if (s > ACC_MAX) begin
      sat      = 1'b1;
      acc_step = ACC_MAX[ACC_W-1:0];
    end else if (s < ACC_MIN) begin
      sat      = 1'b1;
      acc_step = ACC_MIN[ACC_W-1:0];
    end else begin
      sat      = 1'b0;
      acc_step = s[ACC_W-1:0];
    end
`else
    sat      = 1'b0;
    acc_step = (acc <<< 1) + ACC_W'(bin);
`endif
  endfunction

  logic                     accept_s;
  logic                     s1_valid_r, s1_last_r;
  logic [SUM_W-1:0]         s1_sum_r [LANES];
  logic [LANES-1:0]         s1_sgn_r, s1_mask_r;
  logic signed [DW-1:0]     delta_s [NBINS];
  logic signed [DW-1:0]     d_r [NBINS];
  logic                     d_valid_r, d_last_r;
  logic signed [CNT_W-1:0]  bins_r [NBINS];
  logic signed [CNT_W-1:0]  bin_next_s [NBINS];
  logic [NBINS-1:0]         bin_sat_s;
  logic                     bin_sat_any_s;
  state_t                   state_r, state_next;
  logic signed [ACC_W-1:0]  acc_r, acc_next, step_acc_s;
  logic                     step_sat_s, acc_sat_s;
  logic [SUM_W-1:0]         k_r, k_next;
  logic                     out_valid_r, out_valid_next;
  logic [ACC_W-1:0]         out_result_r, out_result_next;
  logic                     ovf_r, ovf_next;
  logic                     in_ready_r, in_ready_next;
  logic                     frame_clear_s;

  assign accept_s   = IN_VALID && in_ready_r;
  assign IN_READY   = in_ready_r;
  assign OUT_VALID  = out_valid_r;
  assign OUT_RESULT = out_result_r;
  assign OUT_OVF    = ovf_r;

  // S1: per-lane exponent sum, product sign and mask for an accepted beat.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_sgn_r   <= {LANES{1'b0}};
      s1_mask_r  <= {LANES{1'b0}};
      for (int i = 0; i < LANES; i++) s1_sum_r[i] <= {SUM_W{1'b0}};
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_last_r  <= IN_LAST;
      s1_sgn_r   <= A_SIGNS ^ B_SIGNS;
      s1_mask_r  <= LANE_MASK;
      for (int i = 0; i < LANES; i++) begin
        s1_sum_r[i] <= {1'b0, A_EXPS[i*EXP_W +: EXP_W]} + {1'b0, B_EXPS[i*EXP_W +: EXP_W]};
      end
    end else begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
    end
  end

  // Per-bin signed lane count for the beat in S1 (zero when S1 is empty).
  always_comb begin
    for (int k = 0; k < NBINS; k++) begin
      delta_s[k] = {DW{1'b0}};
      for (int i = 0; i < LANES; i++) begin
        if (s1_valid_r && s1_mask_r[i] && (s1_sum_r[i] == SUM_W'(k))) begin
          if (s1_sgn_r[i]) begin
            delta_s[k] = delta_s[k] - D_ONE;
          end else begin
            delta_s[k] = delta_s[k] + D_ONE;
          end
        end else begin
          delta_s[k] = delta_s[k];
        end
      end
    end
  end

  // Delta register: keeps the lane-count tree and the bin adders in separate cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      d_valid_r <= 1'b0;
      d_last_r  <= 1'b0;
      for (int k = 0; k < NBINS; k++) d_r[k] <= {DW{1'b0}};
    end else begin
      d_valid_r <= s1_valid_r;
      d_last_r  <= s1_valid_r && s1_last_r;
      for (int k = 0; k < NBINS; k++) d_r[k] <= delta_s[k];
    end
  end

  // Next bin values and the combined saturation indication.
  always_comb begin
    bin_sat_any_s = 1'b0;
    for (int k = 0; k < NBINS; k++) begin
      bin_next_s[k] = bin_add(bins_r[k], d_r[k], bin_sat_s[k]);
      bin_sat_any_s = bin_sat_any_s | bin_sat_s[k];
    end
  end

  // Histogram bins: accumulate deltas, clear when the result is consumed.
  always_ff @(posedge CLK) begin
    if (RST || frame_clear_s) begin
      for (int k = 0; k < NBINS; k++) bins_r[k] <= {CNT_W{1'b0}};
    end else if (d_valid_r) begin
      for (int k = 0; k < NBINS; k++) bins_r[k] <= bin_next_s[k];
    end else begin
      for (int k = 0; k < NBINS; k++) bins_r[k] <= bins_r[k];
    end
  end

  // Horner step on the bin currently selected by the reduction index.
  always_comb begin
    step_sat_s = 1'b0;
    step_acc_s = acc_step(acc_r, bins_r[k_r], step_sat_s);
  end

  // Frame FSM next-state and output values.
  always_comb begin
    state_next      = state_r;
    acc_next        = acc_r;
    k_next          = k_r;
    out_valid_next  = out_valid_r;
    out_result_next = out_result_r;
    acc_sat_s       = 1'b0;
    frame_clear_s   = 1'b0;
    case (state_r)
      ST_ACCUM: begin
        if (d_valid_r && d_last_r) begin
          state_next = ST_REDUCE;
          acc_next   = {ACC_W{1'b0}};
          k_next     = K_LAST;
        end else begin
          state_next = ST_ACCUM;
        end
      end
      ST_REDUCE: begin
        acc_next  = step_acc_s;
        acc_sat_s = step_sat_s;
        if (k_r == {SUM_W{1'b0}}) begin
          state_next      = ST_OUTPUT;
          out_valid_next  = 1'b1;
          out_result_next = step_acc_s;
        end else begin
          k_next = k_r - {{(SUM_W-1){1'b0}}, 1'b1};
        end
      end
      ST_OUTPUT: begin
        if (OUT_READY) begin
          state_next      = ST_ACCUM;
          out_valid_next  = 1'b0;
          out_result_next = {ACC_W{1'b0}};
          acc_next        = {ACC_W{1'b0}};
          frame_clear_s   = 1'b1;
        end else begin
          state_next = ST_OUTPUT;
        end
      end
      default: begin
        state_next      = ST_ACCUM;
        out_valid_next  = 1'b0;
        out_result_next = {ACC_W{1'b0}};
        acc_next        = {ACC_W{1'b0}};
        frame_clear_s   = 1'b1;
      end
    endcase
    // Stop taking beats once a last beat is in flight, until the frame is consumed.
    in_ready_next = (state_next == ST_ACCUM) && !(accept_s && IN_LAST) &&
                    !(s1_valid_r && s1_last_r);
    if (frame_clear_s) begin
      ovf_next = 1'b0;
    end else begin
      ovf_next = ovf_r | acc_sat_s | (d_valid_r & bin_sat_any_s);
    end
  end

  // Frame FSM and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ST_ACCUM;
      acc_r        <= {ACC_W{1'b0}};
      k_r          <= {SUM_W{1'b0}};
      out_valid_r  <= 1'b0;
      out_result_r <= {ACC_W{1'b0}};
      ovf_r        <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      state_r      <= state_next;
      acc_r        <= acc_next;
      k_r          <= k_next;
      out_valid_r  <= out_valid_next;
      out_result_r <= out_result_next;
      ovf_r        <= ovf_next;
      in_ready_r   <= in_ready_next;
    end
  end

endmodule

// File: tb/tb_pe_hist_mac.sv
// -----------------------------------------------------------------------------
// tb_pe_hist_mac
// Directed and randomized bench for pe_hist_mac. Expected results come from
// a reference that sums +/-2^(A+B) over the unmasked lanes of every beat in a
// frame. A second instance with CNT_W=4 covers bin overflow behaviour in both
// builds (PE_HIST_SAT_EN defined or not).
// -----------------------------------------------------------------------------
module tb_pe_hist_mac;

  localparam int LANES = 16;
  localparam int EXP_W = 3;
  localparam int ACC_W = 32;
  localparam int VW    = LANES * EXP_W;

`ifdef PE_HIST_SAT_EN
  localparam longint EXP4_RES = 64'sd7;
  localparam logic   EXP4_OVF = 1'b1;
`else
  localparam longint EXP4_RES = 64'sd0;
  localparam logic   EXP4_OVF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             in_valid, in_last, out_ready;
  logic [VW-1:0]    a_exps, b_exps;
  logic [LANES-1:0] a_signs, b_signs, lane_mask;
  logic             in_ready, out_valid, out_ovf;
  logic [ACC_W-1:0] out_result;

  logic             v4, last4, rdy4_out;
  logic [VW-1:0]    a4, b4;
  logic [LANES-1:0] as4, bs4, m4;
  logic             ready4, valid4, ovf4;
  logic [ACC_W-1:0] result4;

  int     tests = 0;
  int     failed = 0;
  int     cyc = 0;
  int     acc_cyc = 0;
  longint model_sum = 0;

  pe_hist_mac dut (
    .CLK(clk), .RST(rst),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_LAST(in_last),
    .A_EXPS(a_exps), .A_SIGNS(a_signs), .B_EXPS(b_exps), .B_SIGNS(b_signs),
    .LANE_MASK(lane_mask),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT_RESULT(out_result), .OUT_OVF(out_ovf)
  );

  pe_hist_mac #(.CNT_W(4)) dut4 (
    .CLK(clk), .RST(rst),
    .IN_VALID(v4), .IN_READY(ready4), .IN_LAST(last4),
    .A_EXPS(a4), .A_SIGNS(as4), .B_EXPS(b4), .B_SIGNS(bs4),
    .LANE_MASK(m4),
    .OUT_VALID(valid4), .OUT_READY(rdy4_out),
    .OUT_RESULT(result4), .OUT_OVF(ovf4)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Present one beat, wait (bounded) for acceptance, and add its terms to the model.
  task automatic send_beat(input logic [VW-1:0] ae, input logic [LANES-1:0] asg,
                           input logic [VW-1:0] be, input logic [LANES-1:0] bsg,
                           input logic [LANES-1:0] mask, input logic last);
    int guard;
    int ea, eb;
    longint term;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        ea = int'(ae[i*EXP_W +: EXP_W]);
        eb = int'(be[i*EXP_W +: EXP_W]);
        term = longint'(1) << (ea + eb);
        if (asg[i] ^ bsg[i]) model_sum -= term;
        else                 model_sum += term;
      end
    end
    a_exps = ae; a_signs = asg; b_exps = be; b_signs = bsg;
    lane_mask = mask; in_last = last; in_valid = 1'b1;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait (bounded) for OUT_VALID and compare result, overflow flag and latency.
  task automatic wait_result(input string tag, input longint expv, input logic expovf);
    int guard;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_latency"}, cyc - acc_cyc, 17);
    check({tag, "_result"}, $signed(out_result), expv);
    check({tag, "_ovf"}, out_ovf, expovf);
  endtask

  // Hold the result for n cycles checking stability, then consume it.
  task automatic hold_and_consume(input string tag, input int n, input longint expv);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_result"}, $signed(out_result), expv);
      check({tag, "_hold_inready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_after_valid"}, out_valid, 0);
    check({tag, "_after_inready"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] ae, be;
    logic [LANES-1:0] asg, bsg, msk;
    int nb, h, first_acc, guard, saw;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    a_exps = '0; b_exps = '0; a_signs = '0; b_signs = '0; lane_mask = '0;
    v4 = 1'b0; last4 = 1'b0; rdy4_out = 1'b1;
    a4 = '0; b4 = '0; as4 = '0; bs4 = '0; m4 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", $signed(out_result), 0);
    check("rst_out_ovf", out_ovf, 0);

    // Scenario 1: one beat, all lanes 1+2, positive -> 16 * 2^3
    model_sum = 0;
    send_beat(48'h249249249249, 16'h0000, 48'h492492492492, 16'h0000, 16'hFFFF, 1'b1);
    check("s1_inready_low", in_ready, 0);
    wait_result("s1", 128, 1'b0);
    @(posedge clk); #1;
    check("s1_after_valid", out_valid, 0);
    check("s1_after_inready", in_ready, 1);

    // Scenario 2: -2^14 then +1
    model_sum = 0;
    send_beat(48'h7, 16'h0001, 48'h7, 16'h0000, 16'h0001, 1'b0);
    send_beat(48'h0, 16'h0000, 48'h0, 16'h0000, 16'h0020, 1'b1);
    wait_result("s2", -16383, 1'b0);
    @(posedge clk); #1;

    // Scenario 3: three fully masked beats, then back-pressure on the result
    out_ready = 1'b0;
    model_sum = 0;
    for (int b = 0; b < 3; b++) begin
      ae = VW'({$urandom(), $urandom()});
      be = VW'({$urandom(), $urandom()});
      send_beat(ae, 16'hFFFF, be, 16'h0000, 16'h0000, (b == 2));
    end
    wait_result("s3", 0, 1'b0);
    hold_and_consume("s3", 5, 0);

    // Scenario 6: eight back-to-back beats, lane i exponent i%8
    model_sum = 0;
    for (int i = 0; i < LANES; i++) ae[i*EXP_W +: EXP_W] = EXP_W'(i % 8);
    first_acc = 0;
    for (int b = 0; b < 8; b++) begin
      send_beat(ae, 16'h0000, 48'h0, 16'h0000, 16'hFFFF, (b == 7));
      if (b == 0) first_acc = acc_cyc;
    end
    check("s6_no_stall", acc_cyc - first_acc, 7);
    wait_result("s6", 4080, 1'b0);
    @(posedge clk); #1;

    // Randomized frames against the reference sum
    for (int f = 0; f < 8; f++) begin
      model_sum = 0;
      out_ready = 1'b0;
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        ae  = VW'({$urandom(), $urandom()});
        be  = VW'({$urandom(), $urandom()});
        asg = LANES'($urandom());
        bsg = LANES'($urandom());
        msk = ($urandom_range(0, 5) == 0) ? 16'h0000 : LANES'($urandom());
        send_beat(ae, asg, be, bsg, msk, (b == nb - 1));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #0;
      end
      wait_result($sformatf("rnd%0d", f), model_sum, 1'b0);
      h = $urandom_range(0, 3);
      hold_and_consume($sformatf("rnd%0d", f), h, model_sum);
    end

    // Scenario 5: reset in the middle of the reduction
    out_ready = 1'b1;
    model_sum = 0;
    send_beat(48'h249249249249, 16'h0000, 48'h492492492492, 16'h0000, 16'hFFFF, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("s5_mid_reduce_inready", in_ready, 0);
    check("s5_mid_reduce_valid", out_valid, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("s5_rst_inready", in_ready, 1);
    check("s5_rst_valid", out_valid, 0);
    check("s5_rst_result", $signed(out_result), 0);
    check("s5_rst_ovf", out_ovf, 0);
    saw = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) saw = 1;
    end
    check("s5_no_valid_after_rst", saw, 0);
    model_sum = 0;
    send_beat(48'h249249249249, 16'h0000, 48'h492492492492, 16'h0000, 16'hFFFF, 1'b1);
    wait_result("s5_new", 128, 1'b0);
    @(posedge clk); #1;

    // Scenario 4: CNT_W=4 instance, 16 positive lanes all landing in bin 0
    m4 = 16'hFFFF; last4 = 1'b1; v4 = 1'b1;
    guard = 0;
    while (ready4 !== 1'b1 && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    check("s4_accept_ready", ready4, 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    v4 = 1'b0; last4 = 1'b0;
    guard = 0;
    while (valid4 !== 1'b1 && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    check("s4_valid", valid4, 1);
    check("s4_latency", cyc - acc_cyc, 17);
    check("s4_result", $signed(result4), EXP4_RES);
    check("s4_ovf", ovf4, EXP4_OVF);
    @(posedge clk); #1;
    check("s4_after_ready", ready4, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pe_hist_mac.md
Name: pe_hist_mac

Overview:
- Parametrised successor of the 16-lane log-domain bit-sparsity PE.
- Per lane, the block adds the A/B exponents, XORs the signs, and drops lanes masked as zero. It then builds a signed per-exponent histogram that accumulates across multiple input beats.
- On the last beat, it reduces the histogram to one signed two's-complement result (sum of bin[k]·2^k).
- It sits between the operand-fetch stage and the array output collector, with valid/ready on both sides.

Parameters:
- LANES, 16, number of parallel exponent/sign lanes.
- EXP_W, 3, exponent code width per operand.
- CNT_W, 8, signed width of each histogram bin register.
- ACC_W, 32, signed width of the reduction accumulator and result.
- (derived) NBINS = 2^(EXP_W+1)-1, number of bins, indexed 0..2·(2^EXP_W-1).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  input beat valid.
- IN_READY  out  1  block accepts a beat this cycle.
- IN_LAST  in  1  beat closes the current accumulation frame.
- A_EXPS  in  LANES·EXP_W  packed A exponents; lane i = bits [i·EXP_W +: EXP_W].
- A_SIGNS  in  LANES  A signs, 1 = negative.
- B_EXPS  in  LANES·EXP_W  packed B exponents.
- B_SIGNS  in  LANES  B signs.
- LANE_MASK  in  LANES  1 = lane carries a nonzero term; 0 = lane skipped.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts the result.
- OUT_RESULT  out  ACC_W  signed frame result.
- OUT_OVF  out  1  sticky overflow flag for the frame.

Behaviour:
- Accept: a beat is accepted when IN_VALID && IN_READY.
- Stage S1 (registered): per lane, sum = A+B (EXP_W+1 bits, no overflow), sgn = A_SIGN^B_SIGN, and the mask bit. S1 also carries a valid bit and a last bit.
- Stage S2 (histogram): on an S1 valid beat, every bin k updates as bin[k] += Σ over lanes with mask=1 and sum==k of (sgn ? -1 : +1). All bins update in the same cycle.
- FSM states:
  - ACCUM: IN_READY = !(last accepted and not yet consumed by S2).
  - REDUCE: entered on the edge where S2 consumes the last beat.
    - acc is cleared on entry.
    - One bin per cycle from k = NBINS-1 down to 0: acc = 2·acc + bin[k].
    - Takes exactly NBINS cycles.
  - OUTPUT: OUT_VALID = 1, OUT_RESULT = acc; these hold stable until OUT_READY.
  - On OUT_VALID && OUT_READY: go to ACCUM next cycle, with bins, acc and OVF cleared in that same edge.
- IN_READY = 0 in REDUCE and OUTPUT.
- Latency: last beat accepted at edge t → S2 update at t+2 → OUT_VALID high after edge t+2+NBINS (t+17 for defaults).
- Back-to-back beats with no bubbles are sustained in ACCUM.
- A frame may be one beat long (IN_LAST on the first beat).
- Empty contribution (all lanes masked): the frame still completes, with result 0.
- Reset, at any state including mid-REDUCE or mid-OUTPUT:
  - state = ACCUM, all bins and acc = 0, S1 valid = 0.
  - OUT_VALID = 0, OUT_RESULT = 0, OUT_OVF = 0, IN_READY = 1 from the first cycle after reset.
- IN_* is ignored while IN_READY = 0.
- OUT_READY is ignored while OUT_VALID = 0.

Optional Feature:
- Macro: PE_HIST_SAT_EN.
- Defined:
  - Bins saturate at ±(2^(CNT_W-1)-1).
  - acc saturates at ±(2^(ACC_W-1)-1) on each Horner step.
  - Any saturation event sets OUT_OVF (sticky until the frame is consumed or reset).
- Undefined:
  - Bins and acc wrap modulo 2^CNT_W / 2^ACC_W.
  - OUT_OVF is tied to 0.

Test Plan:
1. Single beat, all 16 lanes A=1, B=2, signs 0, mask all ones, LAST, OUT_READY=1 → bin3 = 16, OUT_RESULT = 128, OVF = 0, OUT_VALID rises 17 cycles after accept.
2. Two beats:
   - Beat 1: lane0 A=7, B=7, A_SIGN=1, other lanes masked.
   - Beat 2: lane5 A=0, B=0, signs 0, LAST.
   - Expected: OUT_RESULT = -16384+1 = -16383.
3. Frame with LANE_MASK = 0 on all beats, 3 beats → OUT_RESULT = 0. Then hold OUT_READY=0 for 5 cycles → OUT_VALID and OUT_RESULT stable, IN_READY = 0; handshake → IN_READY = 1 next cycle.
4. CNT_W=4, one beat of 16 lanes A=0, B=0, positive:
   - Macro defined → bin0 = 7, OUT_RESULT = 7, OUT_OVF = 1.
   - Macro undefined → OUT_RESULT = 0, OUT_OVF = 0.
5. Assert RST for one cycle during REDUCE (cycle 5 of 15) → OUT_VALID never rises for that frame. A new frame as in scenario 1 then yields 128.
6. Streaming: 8 beats on consecutive cycles, lane i A=i%8, B=0, signs 0, last on beat 8 → all 8 accepted with no stall, bins 0..7 = 16 each, OUT_RESULT = 16·255 = 4080.
